// File: rtl/npu_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npu_wb_pkg
//  Description : Shared write-back definitions: packer state encoding,
//                RAM word byte-lane-half mask constants and RAM word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package npu_wb_pkg;

   // Packer state: IDLE, LOW (waiting for low beat), HIGH (low beat held)
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } wb_state_e;

   // o_wr_mask: bit0 = low half valid, bit1 = high half valid
   localparam logic [1:0] WB_MASK_FULL = 2'b11;
   localparam logic [1:0] WB_MASK_LO   = 2'b01;
   localparam logic [1:0] WB_MASK_NONE = 2'b00;

   // Output-RAM word width (two 256-bit beats)
   localparam int WB_RAM_WORD_W = 512;

endpackage : npu_wb_pkg
`default_nettype wire

// File: rtl/xpe_wb_packer.sv
`default_nettype none
// ============================================================================
//  Module      : xpe_wb_packer
//  Description : Write-back packer. Pairs consecutive DAT_W-bit result beats
//                into 2*DAT_W-bit output-RAM words written at sequential
//                addresses from a programmed base. A layer ends on a
//                programmed word count (0 = unbounded) or on i_flush; a
//                half-filled final word is written with mask 2'b01.
//  Ports       : i_clk/i_rst          clock, synchronous active-high reset
//                i_start              begin layer (latch base + word count)
//                i_addr_start         first write address
//                i_word_num           words per layer, 0 = flush-terminated
//                i_flush              end-of-calculation pulse
//                i_xpe_dat_out/_vld   result beat and its valid
//                o_wr_en/addr/dat/mask  registered RAM write port
//                o_busy/o_done/o_err  layer status (o_err is sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module xpe_wb_packer
   import npu_wb_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH = 8,
   parameter int DAT_W          = 256
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_start,
   input  logic [RAM_ADDR_WIDTH-1:0] i_addr_start,
   input  logic [7:0]                i_word_num,
   input  logic                      i_flush,
   input  logic [DAT_W-1:0]          i_xpe_dat_out,
   input  logic                      i_xpe_dat_vld,
   output logic                      o_wr_en,
   output logic [RAM_ADDR_WIDTH-1:0] o_wr_addr,
   output logic [2*DAT_W-1:0]        o_wr_dat,
   output logic [1:0]                o_wr_mask,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_err
);

   wb_state_e                 state_q, state_d;
   logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]                target_q, target_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [DAT_W-1:0]          lo_q, lo_d;

   logic                      wr_en_q, wr_en_d;
   logic [RAM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [2*DAT_W-1:0]        wr_dat_q, wr_dat_d;
   logic [1:0]                wr_mask_q, wr_mask_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;

   logic [7:0]                cnt_inc;
   logic                      count_hit;

   assign cnt_inc   = cnt_q + 8'd1;
   assign count_hit = (target_q != 8'd0) && (cnt_inc == target_q);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      target_d  = target_q;
      cnt_d     = cnt_q;
      lo_d      = lo_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_dat_d  = wr_dat_q;
      wr_mask_d = WB_MASK_NONE;
      done_d    = 1'b0;
      err_d     = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               addr_d   = i_addr_start;
               target_d = i_word_num;
               cnt_d    = 8'd0;
               err_d    = 1'b0;
               state_d  = ST_LOW;
            end else if (i_xpe_dat_vld) begin
               // No layer open: the beat is lost, flag it
               err_d = 1'b1;
            end
         end

         ST_LOW: begin
            if (i_xpe_dat_vld && i_flush) begin
               // Beat lands in the low half and the layer closes at once
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_dat_d  = {{DAT_W{1'b0}}, i_xpe_dat_out};
               wr_mask_d = WB_MASK_LO;
               addr_d    = addr_q + 1'b1;
               cnt_d     = cnt_inc;
               done_d    = 1'b1;
               state_d   = ST_IDLE;
            end else if (i_xpe_dat_vld) begin
               lo_d    = i_xpe_dat_out;
               state_d = ST_HIGH;
            end else if (i_flush) begin
               // Nothing held: close without writing
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         ST_HIGH: begin
            if (i_xpe_dat_vld) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_dat_d  = {i_xpe_dat_out, lo_q};
               wr_mask_d = WB_MASK_FULL;
               addr_d    = addr_q + 1'b1;
               cnt_d     = cnt_inc;
               if (i_flush || count_hit) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_LOW;
               end
            end else if (i_flush) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_dat_d  = {{DAT_W{1'b0}}, lo_q};
               wr_mask_d = WB_MASK_LO;
               addr_d    = addr_q + 1'b1;
               cnt_d     = cnt_inc;
               done_d    = 1'b1;
               state_d   = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Busy covers the done cycle itself, dropping one cycle later
      busy_d = (state_d != ST_IDLE) || done_d;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         target_q  <= '0;
         cnt_q     <= '0;
         lo_q      <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_dat_q  <= '0;
         wr_mask_q <= WB_MASK_NONE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         target_q  <= target_d;
         cnt_q     <= cnt_d;
         lo_q      <= lo_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_dat_q  <= wr_dat_d;
         wr_mask_q <= wr_mask_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign o_wr_en   = wr_en_q;
   assign o_wr_addr = wr_addr_q;
   assign o_wr_dat  = wr_dat_q;
   assign o_wr_mask = wr_mask_q;
   assign o_busy    = busy_q;
   assign o_done    = done_q;
   assign o_err     = err_q;

endmodule : xpe_wb_packer
`default_nettype wire

// File: tb/tb_xpe_wb_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xpe_wb_packer
//  Description : Self-checking bench for xpe_wb_packer. A queue-based model
//                of the packing rules predicts every output each cycle;
//                directed layers are also pinned with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xpe_wb_packer;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_start;
   logic [7:0]   i_addr_start;
   logic [7:0]   i_word_num;
   logic         i_flush;
   logic [255:0] i_xpe_dat_out;
   logic         i_xpe_dat_vld;
   logic         o_wr_en;
   logic [7:0]   o_wr_addr;
   logic [511:0] o_wr_dat;
   logic [1:0]   o_wr_mask;
   logic         o_busy;
   logic         o_done;
   logic         o_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 i_clk = ~i_clk;

   xpe_wb_packer #(.RAM_ADDR_WIDTH(8), .DAT_W(256)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_start       (i_start),
      .i_addr_start  (i_addr_start),
      .i_word_num    (i_word_num),
      .i_flush       (i_flush),
      .i_xpe_dat_out (i_xpe_dat_out),
      .i_xpe_dat_vld (i_xpe_dat_vld),
      .o_wr_en       (o_wr_en),
      .o_wr_addr     (o_wr_addr),
      .o_wr_dat      (o_wr_dat),
      .o_wr_mask     (o_wr_mask),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_err         (o_err)
   );

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Beat k: 16-bit lane j holds {k, j}
   function automatic logic [255:0] mkbeat(input int k);
      logic [255:0] b;
      for (int j = 0; j < 16; j++) b[j*16 +: 16] = {k[7:0], j[7:0]};
      return b;
   endfunction

   // ---------------- behavioural model ----------------
   bit           m_valid = 0;
   bit           m_active;
   bit           m_err;
   bit           m_end;
   logic [7:0]   m_base;
   logic [7:0]   m_target;
   logic [31:0]  m_nwr;
   logic [255:0] held[$];
   logic         exp_en, exp_done, exp_busy;
   logic [7:0]   exp_addr;
   logic [511:0] exp_dat;
   logic [1:0]   exp_mask;

   always @(posedge i_clk) begin
      if (i_rst) begin
         m_active = 0; m_err = 0; held.delete();
         exp_en = 0; exp_addr = 0; exp_dat = 0; exp_mask = 0;
         exp_done = 0; exp_busy = 0;
      end else begin
         exp_en = 0; exp_mask = 0; exp_done = 0; m_end = 0;
         if (!m_active) begin
            if (i_start) begin
               m_active = 1; m_base = i_addr_start; m_target = i_word_num;
               m_nwr = 0; m_err = 0; held.delete();
            end else if (i_xpe_dat_vld) begin
               m_err = 1;
            end
         end else begin
            if (i_xpe_dat_vld) held.push_back(i_xpe_dat_out);
            if (held.size() == 2) begin
               exp_en = 1; exp_addr = m_base + m_nwr[7:0];
               exp_dat = {held[1], held[0]}; exp_mask = 2'b11;
               m_nwr++; held.delete();
               if (m_target != 0 && m_nwr[7:0] == m_target) m_end = 1;
            end
            if (i_flush && !m_end) begin
               if (held.size() == 1) begin
                  exp_en = 1; exp_addr = m_base + m_nwr[7:0];
                  exp_dat = {256'd0, held[0]}; exp_mask = 2'b01;
                  m_nwr++;
               end
               m_end = 1;
            end
            if (m_end) begin
               exp_done = 1; m_active = 0; held.delete();
            end
         end
         exp_busy = m_active || exp_done;
      end
      m_valid = 1;
   end

   // ---------------- compare + write log ----------------
   logic [7:0]   log_addr[16];
   logic [511:0] log_dat[16];
   logic [1:0]   log_mask[16];
   logic         log_done[16];
   int           log_n = 0;

   always @(negedge i_clk) begin
      if (m_valid) begin
         chk("wr_en",   {511'd0, o_wr_en},   {511'd0, exp_en});
         chk("wr_mask", {510'd0, o_wr_mask}, {510'd0, exp_mask});
         chk("done",    {511'd0, o_done},    {511'd0, exp_done});
         chk("busy",    {511'd0, o_busy},    {511'd0, exp_busy});
         chk("err",     {511'd0, o_err},     {511'd0, m_err});
         if (exp_en) begin
            chk("wr_addr", {504'd0, o_wr_addr}, {504'd0, exp_addr});
            chk("wr_dat",  o_wr_dat, exp_dat);
         end
      end
      if (o_wr_en === 1'b1 && log_n < 16) begin
         log_addr[log_n] = o_wr_addr;
         log_dat[log_n]  = o_wr_dat;
         log_mask[log_n] = o_wr_mask;
         log_done[log_n] = o_done;
         log_n++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic st, input logic [7:0] a, input logic [7:0] wn,
                        input logic fl, input logic v, input logic [255:0] d,
                        input logic r);
      @(posedge i_clk);
      #1;
      i_start = st; i_addr_start = a; i_word_num = wn;
      i_flush = fl; i_xpe_dat_vld = v; i_xpe_dat_out = d; i_rst = r;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 8'h00, 8'h00, 0, 0, 256'd0, 0);
   endtask

   task automatic beat(input int k, input logic fl);
      drive(0, 8'h00, 8'h00, fl, 1, mkbeat(k), 0);
   endtask

   initial begin
      i_rst = 1; i_start = 0; i_addr_start = 0; i_word_num = 0;
      i_flush = 0; i_xpe_dat_vld = 0; i_xpe_dat_out = 0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_outputs", {o_wr_en, o_wr_addr, o_wr_mask, o_busy, o_done, o_err},
          {1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0});
      chk("reset_dat", o_wr_dat, 512'd0);
      idle(2);

      // Count-terminated layer: base 0x10, 3 words
      log_n = 0;
      drive(1, 8'h10, 8'd3, 0, 0, 256'd0, 0);
      for (int k = 0; k < 6; k++) beat(k, 0);
      idle(3);
      chk("t1_nwr", 512'(log_n), 512'd3);
      chk("t1_addr", {log_addr[0], log_addr[1], log_addr[2]}, {8'h10, 8'h11, 8'h12});
      chk("t1_b0_lane0", {496'd0, log_dat[0][15:0]}, {496'd0, 16'h0000});
      chk("t1_b1_lane0", {496'd0, log_dat[0][271:256]}, {496'd0, 16'h0100});
      chk("t1_w2_lanes", {480'd0, log_dat[2][271:256], log_dat[2][15:0]},
          {480'd0, 16'h0500, 16'h0400});
      chk("t1_done_last", {log_done[0], log_done[1], log_done[2]}, {1'b0, 1'b0, 1'b1});

      // Flush-terminated, odd beat count: base 0x20
      log_n = 0;
      drive(1, 8'h20, 8'd0, 0, 0, 256'd0, 0);
      for (int k = 16; k < 19; k++) beat(k, 0);
      drive(0, 8'h00, 8'h00, 1, 0, 256'd0, 0);
      idle(3);
      chk("t2_nwr", 512'(log_n), 512'd2);
      chk("t2_addr_mask", {log_addr[0], log_mask[0], log_addr[1], log_mask[1]},
          {8'h20, 2'b11, 8'h21, 2'b01});
      chk("t2_partial_dat", log_dat[1], {256'd0, mkbeat(18)});
      chk("t2_done", {log_done[0], log_done[1]}, {1'b0, 1'b1});

      // Flush together with the second beat
      log_n = 0;
      drive(1, 8'h30, 8'd0, 0, 0, 256'd0, 0);
      beat(32, 0);
      beat(33, 1);
      idle(3);
      chk("t3_nwr", 512'(log_n), 512'd1);
      chk("t3_word", {log_addr[0], log_mask[0], log_done[0]}, {8'h30, 2'b11, 1'b1});

      // Address wrap 0xFF -> 0x00, then a stray beat after count done
      log_n = 0;
      drive(1, 8'hFF, 8'd2, 0, 0, 256'd0, 0);
      for (int k = 48; k < 52; k++) beat(k, 0);
      idle(1);
      beat(60, 0);
      idle(2);
      chk("t4_addr", {log_addr[0], log_addr[1]}, {8'hFF, 8'h00});
      chk("t4_stray_err", {511'd0, o_err}, {511'd0, 1'b1});

      // Beat with no layer open, then i_start clears err
      idle(1);
      beat(70, 0);
      idle(1);
      chk("t5_err_set", {511'd0, o_err}, {511'd0, 1'b1});
      drive(1, 8'h60, 8'd0, 0, 0, 256'd0, 0);
      idle(1);
      chk("t5_err_clr", {511'd0, o_err}, {511'd0, 1'b0});
      // Flush alone in LOW: done, no write
      log_n = 0;
      drive(0, 8'h00, 8'h00, 1, 0, 256'd0, 0);
      idle(1);
      chk("t5_flush_done", {510'd0, o_done, o_wr_en}, {510'd0, 1'b1, 1'b0});
      idle(2);

      // Reset while a low beat is held
      log_n = 0;
      drive(1, 8'h40, 8'd0, 0, 0, 256'd0, 0);
      beat(80, 0);
      drive(0, 8'h00, 8'h00, 0, 0, 256'd0, 1);
      idle(1);
      chk("t6_rst_outputs", {o_wr_en, o_wr_addr, o_wr_mask, o_busy, o_done, o_err},
          {1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0});
      chk("t6_rst_dat", o_wr_dat, 512'd0);
      drive(1, 8'h50, 8'd1, 0, 0, 256'd0, 0);
      beat(90, 0);
      beat(91, 0);
      idle(3);
      chk("t6_nwr", 512'(log_n), 512'd1);
      chk("t6_word", {log_addr[0], log_mask[0], log_done[0]}, {8'h50, 2'b11, 1'b1});
      chk("t6_dat", log_dat[0], {mkbeat(91), mkbeat(90)});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule : tb_xpe_wb_packer
`default_nettype wire
